// File: rtl/serdes_pkg.sv
// Shared states, pin map and framing constants for the tt_serdes UART block.
// Build with SERDES_PARITY_EN defined to add an even-parity bit to every frame.
package serdes_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SEND_START,
        TX_SEND_DATA,
`ifdef SERDES_PARITY_EN
        TX_SEND_PARITY,
`endif
        TX_SEND_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef SERDES_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_RECOVER
    } rx_state_t;

    // Bit positions within uio_in / uio_out
    localparam int TX_START = 0;
    localparam int TX_SER   = 1;
    localparam int RX_SER   = 2;
    localparam int TX_BUSY  = 3;
    localparam int RX_VALID = 4;
    localparam int RX_ERR   = 5;
    localparam int LOOPBACK = 6;

    localparam logic [7:0] UIO_OE = 8'b0011_1010;

`ifdef SERDES_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/serdes_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and output register.
// With SERDES_PARITY_EN defined, a parity bit is checked before the stop bit.
module serdes_rx
    import serdes_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1, line;
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_cnt, bit_d;
    logic [7:0]       shift, shift_d;
    logic             par_bad, par_bad_d;
    logic [7:0]       data_d;
    logic             valid_d, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= 1'b1;
            line         <= 1'b1;
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            par_bad      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync1        <= rx_line;
            line         <= sync1;
            state        <= state_d;
            cnt          <= cnt_d;
            bit_cnt      <= bit_d;
            shift        <= shift_d;
            par_bad      <= par_bad_d;
            rx_data      <= data_d;
            rx_valid     <= valid_d;
            rx_frame_err <= err_d;
        end
    end

    // Start is confirmed half a bit in; every later sample lands one full bit after the last.
    always_comb begin
        state_d   = state;
        cnt_d     = (cnt == BIT_LAST) ? '0 : cnt + 1'b1;
        bit_d     = bit_cnt;
        shift_d   = shift;
        par_bad_d = par_bad;
        data_d    = rx_data;
        valid_d   = 1'b0;
        err_d     = rx_frame_err;
        unique case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (!line) state_d = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_d = {line, shift[7:1]};
                    bit_d   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef SERDES_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef SERDES_PARITY_EN
            RX_PARITY: begin
                if (cnt == BIT_LAST) begin
                    par_bad_d = line ^ (^shift);
                    state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    if (line && !par_bad) begin
                        data_d  = shift;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        state_d = RX_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RX_RECOVER;
                    end
                end
            end
            RX_RECOVER: begin
                cnt_d = '0;
                if (line) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/tt_serdes.sv
// TinyTapeout wrapper: UART transmitter FSM, loopback mux and serdes_rx instance.
// Define SERDES_PARITY_EN to send and check an even-parity bit (11-bit frames).
module tt_serdes
    import serdes_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_data, tx_data_d;
    logic             start_q, start_rise, tx_go;
    logic             tx_serial, tx_busy;
    logic             rx_src, rx_valid, rx_frame_err;
    logic [7:0]       rx_data;
    logic             unused_inputs;

    assign start_rise = uio_in[TX_START] & ~start_q;
    assign tx_go      = start_rise & ena & (tx_state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
            start_q  <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_data  <= tx_data_d;
            start_q  <= uio_in[TX_START];
        end
    end

    // Edges arriving outside IDLE (or with ena low) are simply dropped.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = (tx_cnt == BIT_LAST) ? '0 : tx_cnt + 1'b1;
        tx_bit_d   = tx_bit;
        tx_data_d  = tx_data;
        tx_serial  = 1'b1;
        tx_busy    = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_busy  = 1'b0;
                tx_cnt_d = '0;
                if (tx_go) begin
                    tx_data_d  = ui_in;
                    tx_state_d = TX_SEND_START;
                end
            end
            TX_SEND_START: begin
                tx_serial = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_SEND_DATA;
                end
            end
            TX_SEND_DATA: begin
                tx_serial = tx_data[tx_bit];
                if (tx_cnt == BIT_LAST) begin
                    tx_bit_d = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) begin
`ifdef SERDES_PARITY_EN
                        tx_state_d = TX_SEND_PARITY;
`else
                        tx_state_d = TX_SEND_STOP;
`endif
                    end
                end
            end
`ifdef SERDES_PARITY_EN
            TX_SEND_PARITY: begin
                tx_serial = ^tx_data;
                if (tx_cnt == BIT_LAST) tx_state_d = TX_SEND_STOP;
            end
`endif
            TX_SEND_STOP: begin
                if (tx_cnt == BIT_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign rx_src = uio_in[LOOPBACK] ? tx_serial : uio_in[RX_SER];

    serdes_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_line     (rx_src),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    always_comb begin
        uio_out           = 8'h00;
        uio_out[TX_SER]   = tx_serial;
        uio_out[TX_BUSY]  = tx_busy;
        uio_out[RX_VALID] = rx_valid;
        uio_out[RX_ERR]   = rx_frame_err;
    end

    assign uo_out = rx_data;
    assign uio_oe = UIO_OE;

    assign unused_inputs = &{1'b0, uio_in[7], uio_in[5:3], uio_in[1]};

endmodule

// File: tb/tb_tt_serdes.sv
// Randomized bench for tt_serdes, checked against a frame-level model of the UART protocol.
// Honors SERDES_PARITY_EN for the 11-bit frame variant.
`timescale 1ns/1ps
module tb_tt_serdes;

    localparam int CPB = 8;
`ifdef SERDES_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         checks = 0;
    int         failures = 0;
    int         valid_seen = 0;
    logic [7:0] exp_byte;
    logic       exp_err;

    tt_serdes #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (uio_out[4] === 1'b1) valid_seen++;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Element k is the k-th bit on the wire; bad_chk corrupts the check bit (parity, else stop).
    function automatic logic [NBITS-1:0] make_frame(input logic [7:0] b, input logic stop_val,
                                                    input logic bad_chk);
        logic [NBITS-1:0] f;
        f    = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef SERDES_PARITY_EN
        f[9]       = (^b) ^ bad_chk;
        f[NBITS-1] = stop_val;
`else
        f[NBITS-1] = stop_val & ~bad_chk;
`endif
        return f;
    endfunction

    // Drive one serial frame on rx_serial, then hold the line idle.
    task automatic applyStimulus(input logic [NBITS-1:0] f);
        for (int k = 0; k < NBITS; k++) begin
            uio_in[2] = f[k];
            tick(CPB);
        end
        uio_in[2] = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic send_rx(input string tag, input logic [7:0] b, input logic stop_val,
                           input logic bad_chk);
        int  v0;
        logic good;
        v0   = valid_seen;
        good = stop_val && !bad_chk;
        applyStimulus(make_frame(b, stop_val, bad_chk));
        if (good) begin
            exp_byte = b;
            exp_err  = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        checkOutput({tag, " valid_count"}, valid_seen - v0, good ? 1 : 0);
        checkOutput({tag, " uo_out"}, uo_out, exp_byte);
        checkOutput({tag, " frame_err"}, uio_out[5], exp_err);
    endtask

    // Transmit in loopback, checking every cycle of the serial waveform and busy window.
    task automatic send_tx(input string tag, input logic [7:0] b, input bit inject);
        logic [NBITS-1:0] f;
        int bad_cycles, busy_low, busy_after, v0;
        f = make_frame(b, 1'b1, 1'b0);
        bad_cycles = 0;
        busy_low   = 0;
        busy_after = 0;
        v0 = valid_seen;
        ui_in     = b;
        uio_in[0] = 1'b1;
        tick();
        ui_in = 8'($urandom);
        checkOutput({tag, " busy_rise"}, uio_out[3], 1'b1);
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (uio_out[1] !== f[k]) bad_cycles++;
                if (uio_out[3] !== 1'b1) busy_low++;
                if (inject && k == 4 && c == 0) begin
                    ui_in     = 8'h3C;
                    uio_in[0] = 1'b1;
                end else begin
                    uio_in[0] = 1'b0;
                end
                tick();
            end
        end
        checkOutput({tag, " serial_bits"}, bad_cycles, 0);
        checkOutput({tag, " busy_width"}, busy_low, 0);
        checkOutput({tag, " busy_fall"}, uio_out[3], 1'b0);
        for (int i = 0; i < 2 * CPB; i++) begin
            if (uio_out[3] !== 1'b0) busy_after++;
            tick();
        end
        exp_byte = b;
        exp_err  = 1'b0;
        checkOutput({tag, " no_requeue"}, busy_after, 0);
        checkOutput({tag, " valid_count"}, valid_seen - v0, 1);
        checkOutput({tag, " uo_out"}, uo_out, exp_byte);
        checkOutput({tag, " frame_err"}, uio_out[5], exp_err);
    endtask

    initial begin
        int busy_cnt, v0;
        logic [7:0] b;
        logic stop_val, bad_chk;

        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h04;
        exp_byte = 8'h00;
        exp_err  = 1'b0;
        tick(2);
        checkOutput("reset uo_out", uo_out, 8'h00);
        checkOutput("reset uio_out", uio_out, 8'b0000_0010);
        checkOutput("reset uio_oe", uio_oe, 8'b0011_1010);
        rst = 1'b0;
        tick(2);

        // Loopback transmit, including a dropped mid-frame start
        uio_in[6] = 1'b1;
        send_tx("tx_a5", 8'hA5, 1'b1);
        send_tx("tx_07", 8'h07, 1'b0);
        for (int i = 0; i < 4; i++) send_tx("tx_rand", 8'($urandom), 1'b0);

        // Start edge with ena low produces nothing
        ena       = 1'b0;
        uio_in[0] = 1'b1;
        busy_cnt  = 0;
        tick();
        uio_in[0] = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            if (uio_out[3] !== 1'b0) busy_cnt++;
            tick();
        end
        checkOutput("ena_low no_tx", busy_cnt, 0);
        ena = 1'b1;

        // External receive path
        uio_in[6] = 1'b0;
        uio_in[2] = 1'b1;
        tick(2 * CPB);
        send_rx("rx_bad_stop", 8'h5A, 1'b0, 1'b0);
        send_rx("rx_c3", 8'hC3, 1'b1, 1'b0);
        send_rx("rx_bad_chk", 8'h07, 1'b1, 1'b1);
        send_rx("rx_recover", 8'h81, 1'b1, 1'b0);

        // Two-cycle glitch must be rejected silently
        v0 = valid_seen;
        uio_in[2] = 1'b0;
        tick(2);
        uio_in[2] = 1'b1;
        tick(3 * CPB);
        checkOutput("glitch valid_count", valid_seen - v0, 0);
        checkOutput("glitch frame_err", uio_out[5], 1'b0);
        checkOutput("glitch uo_out", uo_out, exp_byte);
        send_rx("rx_after_glitch", 8'h96, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            b        = 8'($urandom);
            stop_val = ($urandom_range(0, 3) != 0);
            bad_chk  = ($urandom_range(0, 3) == 0);
            send_rx("rx_rand", b, stop_val, bad_chk);
        end

        // Reset in the middle of a loopback frame
        uio_in[6] = 1'b1;
        ui_in     = 8'h3F;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        tick(5 * CPB);
        rst = 1'b1;
        tick();
        checkOutput("midreset uio_out", uio_out, 8'b0000_0010);
        checkOutput("midreset uo_out", uo_out, 8'h00);
        rst = 1'b0;
        tick(2);
        send_tx("tx_after_reset", 8'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
